// File: rtl/keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : 4x4 matrix keypad scanner. Drives one active-low row at a
//               time, synchronizes the columns, debounces press and release
//               and emits a single key_valid pulse per physical press.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_ctrl #(
  parameter int SCAN_DIV = 12000,
  parameter int DB_TICKS = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] columns,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [1:0] key_row,
  output logic [1:0] key_col,
  output logic       key_held
);

  localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int c_DB_W  = (DB_TICKS > 0) ? $clog2(DB_TICKS + 1) : 1;
  localparam logic [c_DIV_W-1:0] c_DIV_LAST  = c_DIV_W'(SCAN_DIV - 1);
  localparam logic [c_DB_W-1:0]  c_DB_TARGET = c_DB_W'(DB_TICKS);
  localparam logic [c_DB_W-1:0]  c_DB_ONE    = c_DB_W'(1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  logic [3:0]         r_col_meta;
  logic [3:0]         r_col_s;
  logic [c_DIV_W-1:0] r_div_cnt;
  state_t             r_state;
  logic [1:0]         r_row_idx;
  logic [1:0]         r_lat_col;
  logic [c_DB_W-1:0]  r_db_cnt;
  logic               r_key_valid;
  logic               r_key_held;
  logic [1:0]         r_key_row;
  logic [1:0]         r_key_col;

  state_t             w_state_nxt;
  logic [1:0]         w_row_idx_nxt;
  logic [1:0]         w_lat_col_nxt;
  logic [c_DB_W-1:0]  w_db_cnt_nxt;
  logic               w_key_valid_nxt;
  logic               w_key_held_nxt;
  logic [1:0]         w_key_row_nxt;
  logic [1:0]         w_key_col_nxt;
  logic               w_tick;
  logic [1:0]         w_det_col;
  logic               w_lat_bit;

  // Two-flop synchronizer; idle (all high) out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col_meta <= 4'b1111;
      r_col_s    <= 4'b1111;
    end else begin
      r_col_meta <= columns;
      r_col_s    <= r_col_meta;
    end
  end

  // Free-running scan divider; never paused by the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_div_cnt <= '0;
    end else if (r_div_cnt == c_DIV_LAST) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + c_DIV_W'(1);
    end
  end

  assign w_tick    = (r_div_cnt == c_DIV_LAST);
  assign w_lat_bit = r_col_s[r_lat_col];

  // Lowest-index low column wins when several keys share the active row.
  always_comb begin
    w_det_col = 2'd3;
    if (!r_col_s[0])      w_det_col = 2'd0;
    else if (!r_col_s[1]) w_det_col = 2'd1;
    else if (!r_col_s[2]) w_det_col = 2'd2;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_SCAN;
      r_row_idx   <= 2'd0;
      r_lat_col   <= 2'd0;
      r_db_cnt    <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
      r_key_row   <= 2'd0;
      r_key_col   <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_row_idx   <= w_row_idx_nxt;
      r_lat_col   <= w_lat_col_nxt;
      r_db_cnt    <= w_db_cnt_nxt;
      r_key_valid <= w_key_valid_nxt;
      r_key_held  <= w_key_held_nxt;
      r_key_row   <= w_key_row_nxt;
      r_key_col   <= w_key_col_nxt;
    end
  end

  // Next-state logic: all decisions are taken on scan ticks only.
  always_comb begin
    w_state_nxt     = r_state;
    w_row_idx_nxt   = r_row_idx;
    w_lat_col_nxt   = r_lat_col;
    w_db_cnt_nxt    = r_db_cnt;
    w_key_valid_nxt = 1'b0;
    w_key_held_nxt  = r_key_held;
    w_key_row_nxt   = r_key_row;
    w_key_col_nxt   = r_key_col;
    case (r_state)
      ST_SCAN: begin
        if (w_tick) begin
          if (r_col_s == 4'b1111) begin
            w_row_idx_nxt = r_row_idx + 2'd1;
          end else begin
            w_lat_col_nxt = w_det_col;
            w_db_cnt_nxt  = c_DB_ONE;
            w_state_nxt   = ST_DEBOUNCE;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (w_tick) begin
          if (!w_lat_bit) begin
            if (r_db_cnt == c_DB_TARGET) begin
              w_state_nxt     = ST_HELD;
              w_key_row_nxt   = r_row_idx;
              w_key_col_nxt   = r_lat_col;
              w_key_valid_nxt = 1'b1;
              w_key_held_nxt  = 1'b1;
            end else begin
              w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
            end
          end else begin
            // Bounce during press qualification: drop it silently.
            w_state_nxt   = ST_SCAN;
            w_row_idx_nxt = r_row_idx + 2'd1;
          end
        end
      end
      ST_HELD: begin
        if (w_tick && w_lat_bit) begin
          w_db_cnt_nxt = c_DB_ONE;
          w_state_nxt  = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        if (w_tick) begin
          if (w_lat_bit) begin
            if (r_db_cnt == c_DB_TARGET) begin
              w_state_nxt    = ST_SCAN;
              w_row_idx_nxt  = r_row_idx + 2'd1;
              w_key_held_nxt = 1'b0;
            end else begin
              w_db_cnt_nxt = r_db_cnt + c_DB_ONE;
            end
          end else begin
            // Release bounce: still the same press, no new event.
            w_state_nxt = ST_HELD;
          end
        end
      end
      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

  assign rows      = ~(4'b0001 << r_row_idx);
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;
  assign key_row   = r_key_row;
  assign key_col   = r_key_col;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_keypad_scan_ctrl
// Description : Self-checking bench for keypad_scan_ctrl: a behavioural
//               keypad drives the columns from the row lines, and a
//               run-length reference model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DB_TICKS = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  columns;
  logic [3:0]  rows;
  logic        key_valid;
  logic [1:0]  key_row;
  logic [1:0]  key_col;
  logic        key_held;
  logic [15:0] keys;        // bit r*4+c = key at row r, column c pressed

  int total = 0;
  int bad = 0;
  int pulses = 0;

  // Reference model: tick phase, sync pipe and run lengths of qualifying ticks
  int         m_div;
  logic [3:0] m_s1, m_s2;
  int         m_row, m_lat, m_press_run, m_rel_run, m_krow, m_kcol, m_ticks;
  bit         m_locked, m_accepted, m_pulse;

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its column to its row when driven low.
  always_comb begin
    columns = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && rows[r] == 1'b0) columns[c] = 1'b0;
  end

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DB_TICKS(DB_TICKS)) dut (
    .clk      (clk),
    .reset    (reset),
    .columns  (columns),
    .rows     (rows),
    .key_valid(key_valid),
    .key_row  (key_row),
    .key_col  (key_col),
    .key_held (key_held)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int first_low(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (!v[i]) return i;
    return 0;
  endfunction

  // Advance the model across one rising edge with the given inputs.
  task automatic model_step(input logic [3:0] col_in, input logic rst_in);
    bit tick;
    logic [3:0] cs;
    if (rst_in) begin
      m_div = 0; m_s1 = 4'hF; m_s2 = 4'hF; m_row = 0; m_lat = 0;
      m_press_run = 0; m_rel_run = 0; m_krow = 0; m_kcol = 0;
      m_locked = 0; m_accepted = 0; m_pulse = 0;
    end else begin
      tick  = (m_div == SCAN_DIV - 1);
      m_div = (m_div + 1) % SCAN_DIV;
      cs    = m_s2;
      m_s2  = m_s1;
      m_s1  = col_in;
      m_pulse = 0;
      if (tick) begin
        m_ticks++;
        if (!m_locked) begin
          if (cs == 4'hF) m_row = (m_row + 1) % 4;
          else begin
            m_lat = first_low(cs); m_locked = 1; m_accepted = 0; m_press_run = 1;
          end
        end else if (!m_accepted) begin
          if (cs[m_lat] == 1'b0) begin
            m_press_run++;
            if (m_press_run == DB_TICKS + 1) begin
              m_accepted = 1; m_rel_run = 0; m_pulse = 1;
              m_krow = m_row; m_kcol = m_lat;
            end
          end else begin
            m_locked = 0; m_row = (m_row + 1) % 4;
          end
        end else begin
          if (cs[m_lat] == 1'b1) begin
            m_rel_run++;
            if (m_rel_run == DB_TICKS + 1) begin
              m_locked = 0; m_accepted = 0; m_row = (m_row + 1) % 4;
            end
          end else begin
            m_rel_run = 0;
          end
        end
      end
    end
  endtask

  // One clock: step the model with the settled inputs, then compare outputs.
  task automatic cycle();
    logic [3:0] exp_rows;
    #1;
    model_step(columns, reset);
    @(posedge clk);
    @(negedge clk);
    exp_rows = 4'hF ^ (4'b0001 << m_row);
    chk("rows", 32'(rows), 32'(exp_rows));
    chk("key_valid", 32'(key_valid), 32'(m_pulse));
    chk("key_held", 32'(key_held), 32'(m_accepted));
    chk("key_row", 32'(key_row), 32'(m_krow));
    chk("key_col", 32'(key_col), 32'(m_kcol));
    if (key_valid === 1'b1) pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  initial begin
    int b;
    int t0;
    keys = '0;
    m_ticks = 0;
    reset = 1'b1;

    // Idle scan after reset
    run(3);
    reset = 1'b0;
    pulses = 0;
    run(24);
    chk("idle_pulses", pulses, 0);

    // Single held key row2/col1
    pulses = 0;
    keys = 16'h0200;
    run(80);
    chk("hold_pulses", pulses, 1);
    chk("hold_key", 32'({key_row, key_col}), 32'({2'd2, 2'd1}));
    keys = '0;
    run(40);

    // Press too short to qualify
    pulses = 0;
    keys = 16'h0200;
    b = 0;
    while (!m_locked && b < 100) begin cycle(); b++; end
    chk("short_detect_wait", b < 100, 1);
    t0 = m_ticks;
    b = 0;
    while (m_ticks < t0 + 2 && b < 100) begin cycle(); b++; end
    keys = '0;
    run(40);
    chk("short_pulses", pulses, 0);

    // Release bounce, then a full release
    pulses = 0;
    keys = 16'h0200;
    b = 0;
    while (!m_accepted && b < 200) begin cycle(); b++; end
    chk("bounce_accept_wait", b < 200, 1);
    run(8);
    keys = '0;
    b = 0;
    while (m_rel_run < 1 && b < 50) begin cycle(); b++; end
    keys = 16'h0200;
    b = 0;
    while (m_rel_run != 0 && b < 50) begin cycle(); b++; end
    run(12);
    keys = '0;
    b = 0;
    while (m_accepted && b < 100) begin cycle(); b++; end
    run(8);
    chk("bounce_pulses", pulses, 1);

    // Second key pressed while the first is held
    pulses = 0;
    keys = 16'h0200;
    b = 0;
    while (!m_accepted && b < 200) begin cycle(); b++; end
    run(4);
    keys = 16'h0208;
    run(40);
    chk("ignore_pulses", pulses, 1);
    keys = 16'h0008;
    b = 0;
    while (pulses < 2 && b < 200) begin cycle(); b++; end
    chk("second_key_wait", pulses, 2);
    chk("second_key", 32'({key_row, key_col}), 32'({2'd0, 2'd3}));
    keys = '0;
    run(40);

    // Reset during debounce
    pulses = 0;
    keys = 16'h0200;
    b = 0;
    while (!(m_locked && !m_accepted) && b < 100) begin cycle(); b++; end
    run(2);
    reset = 1'b1;
    keys = '0;
    cycle();
    reset = 1'b0;
    run(40);
    chk("reset_pulses", pulses, 0);

    // Random key activity with occasional resets
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) begin
        case ($urandom_range(0, 3))
          0:       keys = '0;
          3:       keys = (16'd1 << $urandom_range(0, 15)) | (16'd1 << $urandom_range(0, 15));
          default: keys = 16'd1 << $urandom_range(0, 15);
        endcase
      end
      reset = ($urandom_range(0, 399) == 0);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
